// File: rtl/counter_updown_param.sv
// Parameterised up/down counter with an inclusive runtime bound, wrap or saturate
// behaviour at the bound, a registered terminal-count pulse and a sticky bound flag.
module counter_updown_param #(
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             sat_mode,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             bnd_sticky
);

    localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO        = WIDTH'(0);

    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             bnd_sticky_r;

    logic [WIDTH-1:0] load_clamped_s;
    logic [WIDTH-1:0] up_next_s;
    logic [WIDTH-1:0] dn_next_s;
    logic             up_bound_s;
    logic             dn_bound_s;
    logic [WIDTH-1:0] next_count_s;
    logic             boundary_s;
    logic             next_sticky_s;

    // Load value clamped to the current bound.
    always_comb begin
        load_clamped_s = load_val;
        if (load_val > max_val) begin
            load_clamped_s = max_val;
        end else begin
            load_clamped_s = load_val;
        end
    end

    // Up-step candidate: a count at or above the bound (including one left above a
    // freshly lowered bound) is a boundary event rather than a plain increment.
    always_comb begin
        up_bound_s = 1'b0;
        up_next_s  = count_r;
        if (count_r < max_val) begin
            up_bound_s = 1'b0;
            up_next_s  = count_r + ONE;
        end else begin
            up_bound_s = 1'b1;
            if (sat_mode) begin
                up_next_s = max_val;
            end else begin
                up_next_s = ZERO;
            end
        end
    end

    // Down-step candidate: only zero is the boundary, even when above max_val.
    always_comb begin
        dn_bound_s = 1'b0;
        dn_next_s  = count_r;
        if (count_r != ZERO) begin
            dn_bound_s = 1'b0;
            dn_next_s  = count_r - ONE;
        end else begin
            dn_bound_s = 1'b1;
            if (sat_mode) begin
                dn_next_s = ZERO;
            end else begin
                dn_next_s = max_val;
            end
        end
    end

    // Select the next count by priority load > enable > hold.
    always_comb begin
        next_count_s = count_r;
        boundary_s   = 1'b0;
        case ({load, en})
            2'b10, 2'b11: begin
                next_count_s = load_clamped_s;
                boundary_s   = 1'b0;
            end
            2'b01: begin
                if (up_dn) begin
                    next_count_s = up_next_s;
                    boundary_s   = up_bound_s;
                end else begin
                    next_count_s = dn_next_s;
                    boundary_s   = dn_bound_s;
                end
            end
            default: begin
                next_count_s = count_r;
                boundary_s   = 1'b0;
            end
        endcase
    end

    // Sticky flag: a new boundary event wins over a simultaneous clear.
    always_comb begin
        next_sticky_s = bnd_sticky_r;
        if (boundary_s) begin
            next_sticky_s = 1'b1;
        end else if (clr_flags) begin
            next_sticky_s = 1'b0;
        end else begin
            next_sticky_s = bnd_sticky_r;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r      <= RESET_COUNT;
            tc_r         <= 1'b0;
            bnd_sticky_r <= 1'b0;
        end else begin
            count_r      <= next_count_s;
            tc_r         <= boundary_s;
            bnd_sticky_r <= next_sticky_s;
        end
    end

    assign count      = count_r;
    assign tc         = tc_r;
    assign bnd_sticky = bnd_sticky_r;

endmodule

// File: doc/counter_updown_param.md
COUNTER_UPDOWN_PARAM -- requirements
Module: counter_updown_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (legal 2..32).
REQ-002 SHALL have parameter RESET_VAL, default 0, value loaded into count by reset (must be <= 2^WIDTH-1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  count enable; one step per enabled cycle.
REQ-006 SHALL have port up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port load  input  1  synchronous parallel load request.
REQ-008 SHALL have port load_val  input  WIDTH  value for load.
REQ-009 SHALL have port max_val  input  WIDTH  upper count bound (inclusive); sampled every cycle.
REQ-010 SHALL have port sat_mode  input  1  1 = saturate at bound, 0 = wrap.
REQ-011 SHALL have port clr_flags  input  1  clears sticky flag.
REQ-012 SHALL have port count  output  WIDTH  registered counter value.
REQ-013 SHALL have port tc  output  1  registered terminal-count pulse.
REQ-014 SHALL have port bnd_sticky  output  1  registered sticky "bound reached" flag.

Function
REQ-015 Priority per edge SHALL be: rst > load > en; en=0 and load=0 -> count holds.
REQ-016 Load SHALL set count = min(load_val, max_val); load does not assert tc or set bnd_sticky.
REQ-017 Up step: count < max_val -> count+1; count >= max_val -> boundary event.
REQ-018 Down step: count > 0 -> count-1; count == 0 -> boundary event.
REQ-019 Boundary event, sat_mode=0: up -> count=0; down -> count=max_val.
REQ-020 Boundary event, sat_mode=1: up -> count=max_val (clamps if count > max_val); down -> count holds 0.
REQ-021 Count held above a newly lowered max_val SHALL, on an up step, be treated per REQ-017/019/020; on a down step it decrements normally.
REQ-022 tc SHALL be high for exactly the one cycle following each edge at which a boundary event occurred; in saturate mode it repeats every enabled cycle held at the bound.
REQ-023 max_val == 0: count stays 0; every enabled step is a boundary event.
REQ-024 bnd_sticky SHALL set on any boundary event and clear on clr_flags; simultaneous set and clear -> set wins.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH internally with no carry/borrow leaking into count outside REQ-017..020.
REQ-026 up_dn, sat_mode, max_val changes SHALL take effect at the next edge with no latency or pipeline.

Reset
REQ-027 On rst=1 at an edge: count=RESET_VAL, tc=0, bnd_sticky=0, regardless of load/en/clr_flags.
REQ-028 Reset mid-count SHALL abort the step in that cycle; counting resumes the first edge with rst=0.
REQ-029 Outputs SHALL hold reset values while rst stays high.

Verification (WIDTH=4, RESET_VAL=0)
REQ-030 rst 2 cycles, then en=1, up_dn=0, max_val=15, sat_mode=0 -> count 0,15,14,...; tc high one cycle after the 0->15 edge; bnd_sticky=1.
REQ-031 en=1, up_dn=1, max_val=9, sat_mode=0, from 0 -> count 0..9,0,1; tc one cycle after 9->0; repeats every 10 steps.
REQ-032 sat_mode=1, up_dn=1, max_val=5, en held 10 cycles from 0 -> count stops at 5; tc high every cycle while held at 5 with en=1.
REQ-033 load=1, en=1, load_val=12, max_val=7 -> count=7 next cycle, tc=0; then en=1 up, sat_mode=0 -> count 0 with tc.
REQ-034 count=8, max_val lowered to 3, up step, sat_mode=0 -> count=0, tc=1; with sat_mode=1 -> count=3.
REQ-035 bnd_sticky=1, clr_flags=1 in same cycle as a boundary event -> bnd_sticky stays 1; next cycle clr_flags=1, no event -> 0; rst asserted mid-count with load=1 -> count=0.
